down_counter_timer: RTL and testbench

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

---
 rtl/down_counter_timer.sv | 115 +++++++++++
 tb/tb_down_counter_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with terminal-count pulse,
// optional auto-reload, pause, abort and a DONE handshake.
module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             pause,
   input  logic             abort,
   input  logic             done_ack,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           r_state, w_nx_state;
   logic [WIDTH-1:0] r_out, w_nx_out;
   logic [WIDTH-1:0] r_reload, w_nx_reload;
   logic             r_arm, w_nx_arm;
   logic             r_tc, w_nx_tc;

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_out    <= ZERO;
         r_reload <= ZERO;
         r_arm    <= 1'b0;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_nx_state;
         r_out    <= w_nx_out;
         r_reload <= w_nx_reload;
         r_arm    <= w_nx_arm;
         r_tc     <= w_nx_tc;
      end
   end

   // Next-state and next-datapath decode; abort outranks every other RUN/DONE action.
   always_comb begin
      w_nx_state  = r_state;
      w_nx_out    = r_out;
      w_nx_reload = r_reload;
      w_nx_arm    = r_arm;
      w_nx_tc     = 1'b0;
      case (r_state)
         IDLE: begin
            // abort is deliberately not looked at here
            if (load_valid) begin
               w_nx_out    = load_value;
               w_nx_reload = load_value;
               w_nx_arm    = auto_reload;
               if (load_value == ZERO) begin
                  w_nx_state = DONE;
                  w_nx_tc    = 1'b1;
               end else begin
                  w_nx_state = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               w_nx_state = IDLE;
               w_nx_out   = ZERO;
            end else if (!pause) begin
               if (r_out > ONE) begin
                  w_nx_out = r_out - ONE;
               end else begin
                  // out==1 is the terminal step; out==0 cannot occur in RUN
                  // but is folded in so the count can never wrap
                  w_nx_tc = 1'b1;
                  if (r_arm && (r_reload != ZERO)) begin
                     w_nx_out = r_reload;
                  end else begin
                     w_nx_out   = ZERO;
                     w_nx_state = DONE;
                  end
               end
            end
         end
         DONE: begin
            // load_valid ignored here; load_ready is low
            w_nx_out = ZERO;
            if (abort || done_ack) begin
               w_nx_state = IDLE;
            end
         end
         default: begin
            w_nx_state = IDLE;
            w_nx_out   = ZERO;
         end
      endcase
   end

   assign out        = r_out;
   assign tc         = r_tc;
   assign busy       = (r_state == RUN);
   assign done       = (r_state == DONE);
   assign load_ready = (r_state == IDLE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboarded bench for down_counter_timer: the stimulus pushes the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_down_counter_timer;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] out;
      logic         busy;
      logic         done;
      logic         tc;
      logic         ready;
   } exp_t;

   logic         clk, rst;
   logic         load_valid, load_ready, auto_reload, pause, abort, done_ack;
   logic [W-1:0] load_value, out;
   logic         busy, tc, done;

   exp_t q[$];
   int   vec_cnt  = 0;
   int   miss_cnt = 0;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .auto_reload(auto_reload),
      .pause(pause), .abort(abort), .done_ack(done_ack),
      .out(out), .busy(busy), .tc(tc), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t e_idle(input int o);
      exp_t e;
      e.out = W'(o); e.busy = 1'b0; e.done = 1'b0; e.tc = 1'b0; e.ready = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_run(input int o, input logic t);
      exp_t e;
      e.out = W'(o); e.busy = 1'b1; e.done = 1'b0; e.tc = t; e.ready = 1'b0;
      return e;
   endfunction

   function automatic exp_t e_done(input logic t);
      exp_t e;
      e.out = '0; e.busy = 1'b0; e.done = 1'b1; e.tc = t; e.ready = 1'b0;
      return e;
   endfunction

   // one clock edge, then queue what the outputs must be after it
   task automatic tick(input exp_t e);
      @(posedge clk);
      #1;
      q.push_back(e);
   endtask

   task automatic clr();
      load_valid = 1'b0; load_value = '0; auto_reload = 1'b0;
      pause = 1'b0; abort = 1'b0; done_ack = 1'b0;
   endtask

   task automatic do_load(input int v, input logic ar);
      load_valid = 1'b1; load_value = W'(v); auto_reload = ar;
   endtask

   // monitor: compares once per cycle, away from the active edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, g;
         e = q.pop_front();
         g.out = out; g.busy = busy; g.done = done; g.tc = tc; g.ready = load_ready;
         vec_cnt++;
         if (g !== e) begin
            miss_cnt++;
            $display("FAIL vec%0d @%0t: got out=%0d busy=%b done=%b tc=%b rdy=%b, want out=%0d busy=%b done=%b tc=%b rdy=%b",
                     vec_cnt, $time, g.out, g.busy, g.done, g.tc, g.ready,
                     e.out, e.busy, e.done, e.tc, e.ready);
         end
      end
   end

   initial begin
      rst = 1'b0;
      clr();
      // reset state
      tick(e_idle(0));
      rst = 1'b1;

      // load 4, no reload
      do_load(4, 1'b0);
      tick(e_run(4, 1'b0));
      clr();
      tick(e_run(3, 1'b0));
      tick(e_run(2, 1'b0));
      tick(e_run(1, 1'b0));
      tick(e_done(1'b1));
      tick(e_done(1'b0));
      tick(e_done(1'b0));
      done_ack = 1'b1;
      tick(e_idle(0));
      done_ack = 1'b0;
      tick(e_idle(0));

      // load 3, auto-reload
      do_load(3, 1'b1);
      tick(e_run(3, 1'b0));
      clr();
      tick(e_run(2, 1'b0));
      tick(e_run(1, 1'b0));
      tick(e_run(3, 1'b1));
      tick(e_run(2, 1'b0));
      tick(e_run(1, 1'b0));
      tick(e_run(3, 1'b1));
      abort = 1'b1;
      tick(e_idle(0));
      abort = 1'b0;

      // load 6, pause two cycles at 4
      do_load(6, 1'b0);
      tick(e_run(6, 1'b0));
      clr();
      tick(e_run(5, 1'b0));
      tick(e_run(4, 1'b0));
      pause = 1'b1;
      tick(e_run(4, 1'b0));
      tick(e_run(4, 1'b0));
      pause = 1'b0;
      tick(e_run(3, 1'b0));
      tick(e_run(2, 1'b0));
      tick(e_run(1, 1'b0));
      tick(e_done(1'b1));
      done_ack = 1'b1;
      tick(e_idle(0));
      done_ack = 1'b0;

      // load 0, load_valid held through DONE
      do_load(0, 1'b0);
      tick(e_done(1'b1));
      load_value = W'(5);
      tick(e_done(1'b0));
      tick(e_done(1'b0));
      done_ack = 1'b1;
      tick(e_idle(0));
      done_ack = 1'b0;
      tick(e_run(5, 1'b0));
      clr();
      abort = 1'b1;
      tick(e_idle(0));
      abort = 1'b0;

      // load 15, abort at 9 together with done_ack and pause
      do_load(15, 1'b1);
      tick(e_run(15, 1'b0));
      clr();
      for (int k = 14; k >= 9; k--) tick(e_run(k, 1'b0));
      abort = 1'b1; done_ack = 1'b1; pause = 1'b1;
      tick(e_idle(0));
      clr();
      tick(e_idle(0));

      // abort in IDLE does not block a load
      abort = 1'b1;
      do_load(2, 1'b0);
      tick(e_run(2, 1'b0));
      clr();
      tick(e_run(1, 1'b0));
      tick(e_done(1'b1));
      done_ack = 1'b1;
      tick(e_idle(0));
      done_ack = 1'b0;

      // asynchronous reset mid-count, right after out reaches 5
      do_load(7, 1'b0);
      tick(e_run(7, 1'b0));
      clr();
      tick(e_run(6, 1'b0));
      @(posedge clk);
      #1 rst = 1'b0;
      q.push_back(e_idle(0));
      tick(e_idle(0));
      rst = 1'b1;
      do_load(3, 1'b0);
      tick(e_run(3, 1'b0));
      clr();
      tick(e_run(2, 1'b0));
      abort = 1'b1;
      tick(e_idle(0));
      abort = 1'b0;

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         miss_cnt++;
         $display("FAIL drain: %0d entries left in scoreboard, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
